// File: rtl/full_adder_core.sv
// Registered N-bit ripple-carry adder built from chained 1-bit full-adder cells.
// The result is {cout, sum} = a + b + cin, together with a two's-complement
// overflow flag and a zero flag. All outputs are registered with one clock of
// latency. The output registers load only when in_valid is high and hold their
// value otherwise.

// One-bit full-adder cell. It is chained WIDTH times to form the ripple adder.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module full_adder_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // carry_s[i] is the carry into bit i. carry_s[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             zero_s;

  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             zero_q, zero_d;
  logic             vld_q,  vld_d;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry_s[i]),
      .s_o (sum_s[i]),
      .c_o (carry_s[i+1])
    );
  end

  // Signed overflow: the carry into the MSB differs from the carry out of it.
  // With WIDTH=1 the carry into the MSB is cin itself.
  assign ovf_s  = carry_s[WIDTH-1] ^ carry_s[WIDTH];
  // The zero flag looks only at the sum bits. A wrap to 2^WIDTH therefore
  // reads as zero.
  assign zero_s = (sum_s == {WIDTH{1'b0}});

  // Next-state logic: load a fresh result on a valid beat, otherwise hold.
  // out_valid marks only the cycle that follows a capture.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    vld_d  = in_valid;
    if (in_valid) begin
      sum_d  = sum_s;
      cout_d = carry_s[WIDTH];
      ovf_d  = ovf_s;
      zero_d = zero_s;
    end else begin
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
    end
  end

  // Output registers. Reset clears them asynchronously and discards any
  // pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_core.sv
// Bench for full_adder_core. It instantiates the adder at WIDTH = 1, 4 and 8.
// The three instances share in_valid, cin and the low slices of one 8-bit
// operand pair. An arithmetic reference model predicts every output on every
// cycle. Directed vectors also check literal results by hand.
module tb_full_adder_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vld_v = 1'b0;
  logic       cin_v = 1'b0;
  logic [7:0] a_v = 8'h00;
  logic [7:0] b_v = 8'h00;

  logic [0:0] sum1;
  logic       cout1, ovf1, zero1, ov1;
  logic [3:0] sum4;
  logic       cout4, ovf4, zero4, ov4;
  logic [7:0] sum8;
  logic       cout8, ovf8, zero8, ov8;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  // Model state: packed result per instance and the expected out_valid.
  int m_res [3];
  bit m_vld;

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v), .a(a_v[0:0]), .b(b_v[0:0]),
    .cin(cin_v), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1), .out_valid(ov1));

  full_adder_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v), .a(a_v[3:0]), .b(b_v[3:0]),
    .cin(cin_v), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4), .out_valid(ov4));

  full_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v), .a(a_v), .b(b_v),
    .cin(cin_v), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8), .out_valid(ov8));

  function automatic int wof(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  // Reference: integer addition plus a signed range test.
  // Packed result layout: sum in bits [8:0], cout in bit 9, zero in bit 10,
  // ovf in bit 11.
  function automatic int compute(int w, int av, int bv, int cv);
    int mask = (1 << w) - 1;
    int ax   = av & mask;
    int bx   = bv & mask;
    int t    = ax + bx + cv;
    int s    = t & mask;
    int co   = (t >> w) & 1;
    int half = 1 << (w - 1);
    int sa   = (ax >= half) ? ax - (1 << w) : ax;
    int sb   = (bx >= half) ? bx - (1 << w) : bx;
    int st   = sa + sb + cv;
    int ov   = (st > half - 1 || st < -half) ? 1 : 0;
    int z    = (s == 0) ? 1 : 0;
    return s | (co << 9) | (z << 10) | (ov << 11);
  endfunction

  function automatic int dut_res(int i);
    case (i)
      0:       return int'(sum1) | (int'(cout1) << 9) | (int'(zero1) << 10) | (int'(ovf1) << 11);
      1:       return int'(sum4) | (int'(cout4) << 9) | (int'(zero4) << 10) | (int'(ovf4) << 11);
      default: return int'(sum8) | (int'(cout8) << 9) | (int'(zero8) << 10) | (int'(ovf8) << 11);
    endcase
  endfunction

  function automatic int dut_vld(int i);
    case (i)
      0:       return int'(ov1);
      1:       return int'(ov4);
      default: return int'(ov8);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: one-cycle-latency registered result, asynchronous clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      for (int i = 0; i < 3; i++) m_res[i] <= 0;
    end else begin
      m_vld <= vld_v;
      if (vld_v) begin
        for (int i = 0; i < 3; i++)
          m_res[i] <= compute(wof(i), int'(a_v), int'(b_v), int'(cin_v));
      end
    end
  end

  // Compare process: check every instance against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("w%0d_result", wof(i)), dut_res(i), m_res[i]);
          chk($sformatf("w%0d_valid", wof(i)), dut_vld(i), int'(m_vld));
        end
      end
    end
  end

  // Present one vector, let it pass one rising edge, then settle 1 time unit.
  task automatic step(input bit v, input logic [7:0] av, input logic [7:0] bv, input bit c);
    vld_v = v;
    a_v   = av;
    b_v   = bv;
    cin_v = c;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt [8];

  initial begin
    // Expected {sum, cout} for WIDTH=1, indexed by {a, b, cin}.
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    // Pin the reference model against hand-computed results.
    chk("model_wrap",   compute(4, 15, 0, 1),  32'h600);
    chk("model_ovf",    compute(4, 7, 1, 0),   32'h808);
    chk("model_ones",   compute(4, 15, 15, 1), 32'h20F);
    chk("model_w1_001", compute(1, 0, 0, 1),   32'h801);

    #1 rst_n = 1'b0;
    #1;
    cmp_en = 1'b1;
    chk("reset_sum4",  int'(sum4), 0);
    chk("reset_valid", int'(ov4),  0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WIDTH=1 exhaustive truth table.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, {7'd0, k[2]}, {7'd0, k[1]}, k[0]);
      chk($sformatf("tt%0d_sum_cout", k), int'({sum1, cout1}), int'(tt[k]));
      chk($sformatf("tt%0d_ovf", k), int'(ovf1), int'(tt[k][0] ^ k[0]));
      chk($sformatf("tt%0d_valid", k), int'(ov1), 1);
    end

    // WIDTH=4 wrap and signed overflow.
    step(1'b1, 8'h0F, 8'h00, 1'b1);
    chk("wrap_sum",  int'(sum4),  0);
    chk("wrap_cout", int'(cout4), 1);
    chk("wrap_zero", int'(zero4), 1);
    chk("wrap_ovf",  int'(ovf4),  0);
    step(1'b1, 8'h07, 8'h01, 1'b0);
    chk("sovf_sum",  int'(sum4),  8);
    chk("sovf_cout", int'(cout4), 0);
    chk("sovf_ovf",  int'(ovf4),  1);
    chk("sovf_zero", int'(zero4), 0);
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("ones_sum4",  int'(sum4),  15);
    chk("ones_cout4", int'(cout4), 1);
    chk("ones_ovf4",  int'(ovf4),  0);
    chk("ones_sum8",  int'(sum8),  255);
    chk("ones_cout8", int'(cout8), 1);

    // Back-to-back results, then hold with in_valid low.
    step(1'b1, 8'h03, 8'h04, 1'b0);
    chk("b2b0", int'({ov4, zero4, cout4, sum4}), int'({1'b1, 1'b0, 1'b0, 4'd7}));
    step(1'b1, 8'h09, 8'h09, 1'b1);
    chk("b2b1", int'({ov4, zero4, cout4, sum4}), int'({1'b1, 1'b0, 1'b1, 4'd3}));
    step(1'b1, 8'h00, 8'h00, 1'b0);
    chk("b2b2", int'({ov4, zero4, cout4, sum4}), int'({1'b1, 1'b1, 1'b0, 4'd0}));
    step(1'b0, 8'h5A, 8'hC3, 1'b1);
    chk("hold0", int'({ov4, zero4, cout4, sum4}), int'({1'b0, 1'b1, 1'b0, 4'd0}));
    step(1'b0, 8'hA7, 8'h3C, 1'b0);
    chk("hold1", int'({ov4, zero4, cout4, sum4}), int'({1'b0, 1'b1, 1'b0, 4'd0}));

    // Reset asserted mid-stream clears the outputs without a clock edge.
    step(1'b1, 8'h01, 8'h01, 1'b1);
    chk("pre_rst_w1", int'({ov1, sum1, cout1}), int'(3'b111));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_w1", int'({ov1, sum1, cout1}), 0);
    chk("async_rst_w8", int'({ov8, sum8, cout8}), 0);
    vld_v = 1'b1;
    a_v   = 8'hFF;
    b_v   = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_w8", int'({ov8, sum8, cout8}), 0);
    #2 rst_n = 1'b1;
    step(1'b0, 8'h11, 8'h22, 1'b0);
    chk("post_rst_idle", int'({ov8, sum8, cout8}), 0);
    step(1'b1, 8'h11, 8'h22, 1'b0);
    chk("post_rst_cap", int'({ov8, sum8, cout8}), int'({1'b1, 8'h33, 1'b0}));

    // Random regression. The compare process checks every cycle.
    for (int n = 0; n < 1000; n++) begin
      step(($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    step(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
